// File: rtl/xphm_rd.sv
// xphm_rd: read-side stage of the XPH memory.
// A start pulse launches a run of contiguous XPHM reads. Returned data is
// captured into a small output FIFO that feeds a valid/ready stream. A
// credit check (FIFO occupancy plus reads still in the memory pipeline)
// keeps consumer backpressure from ever losing data.
// FIFO_DEPTH must be a power of two and at least RD_LAT+2.

module xphm_rd #(
  parameter int DEPTH      = 2048,
  parameter int DATA_WIDTH = 256,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_pulse,
  input  logic [AW-1:0]         c_addr,
  input  logic [15:0]           n_xphs,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] xph_data,
  output logic                  xph_valid,
  output logic                  xph_last,
  input  logic                  xph_ready
);

  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         next_addr_q, next_addr_d;
  logic [15:0]           remaining_q, remaining_d;
  logic                  done_q, done_d;

  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic [RD_LAT-1:0]     lst_q, lst_d;
  logic [CW-1:0]         in_flight_q, in_flight_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
  logic [FW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fifo_count_q, fifo_count_d;

  logic                  credit_ok;
  logic                  issue;
  logic                  capture;
  logic                  capture_last;
  logic                  push;
  logic                  pop;
  logic                  head_last;

  // Handshake and credit terms shared by the FSM, pipeline and FIFO.
  always_comb begin
    credit_ok    = ({1'b0, fifo_count_q} + {1'b0, in_flight_q}) < SW'(FIFO_DEPTH);
    issue        = (state_q == ISSUE) && credit_ok;
    capture      = vld_q[RD_LAT-1];
    capture_last = lst_q[RD_LAT-1];
    push         = capture;
    xph_valid    = (fifo_count_q != '0);
    head_last    = fifo_last_q[rd_ptr_q];
    pop          = xph_valid && xph_ready;
    xph_data     = xph_valid ? fifo_data_q[rd_ptr_q] : '0;
    xph_last     = xph_valid && head_last;
    busy         = (state_q != IDLE);
    done_pulse   = done_q;
    rd_en        = issue;
    rd_addr      = next_addr_q;
  end

  // Run sequencing: latch the request, issue reads under credit, wait for the last pop.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          next_addr_d = c_addr;
          remaining_d = n_xphs;
          if (n_xphs != 16'd0) begin
            state_d = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          next_addr_d = (next_addr_q == AW'(DEPTH - 1)) ? '0 : next_addr_q + 1'b1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipeline that mirrors the memory latency, plus the in-flight read count.
  always_comb begin
    vld_d    = '0;
    lst_d    = '0;
    vld_d[0] = issue;
    lst_d[0] = issue && (remaining_q == 16'd1);
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
    in_flight_d = in_flight_q;
    if (issue && !capture) begin
      in_flight_d = in_flight_q + CW'(1);
    end else if (!issue && capture) begin
      in_flight_d = in_flight_q - CW'(1);
    end
  end

  // Output FIFO: push on capture, pop on handshake, both allowed together.
  always_comb begin
    fifo_data_d  = fifo_data_q;
    fifo_last_d  = fifo_last_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = dout;
      fifo_last_d[wr_ptr_q] = capture_last;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CW'(1);
    end else if (pop && !push) begin
      fifo_count_d = fifo_count_q - CW'(1);
    end
  end

  // Control, pipeline and pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      next_addr_q  <= '0;
      remaining_q  <= '0;
      done_q       <= 1'b0;
      vld_q        <= '0;
      lst_q        <= '0;
      in_flight_q  <= '0;
      fifo_last_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      remaining_q  <= remaining_d;
      done_q       <= done_d;
      vld_q        <= vld_d;
      lst_q        <= lst_d;
      in_flight_q  <= in_flight_d;
      fifo_last_q  <= fifo_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // FIFO data storage, cleared so no stale entry survives a reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_data_q <= '{default: '0};
    end else begin
      fifo_data_q <= fifo_data_d;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (fifo_count_q == CW'(FIFO_DEPTH))));

  fifo_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(pop && (fifo_count_q == '0)));

  in_flight_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(capture && (in_flight_q == '0)));

endmodule
